// File: rtl/dmem_resp_pkg.sv
// Shared types and default sizing for the data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_state_e;

  localparam int unsigned DMEM_SIZE    = 48;
  localparam int unsigned DMEM_DEPTH   = 64;
  localparam int unsigned DMEM_LATENCY = 2;

endpackage

// File: rtl/dmem_storage.sv
// Word-addressed storage: synchronous write, combinational read. Contents are not reset.
module dmem_storage #(
  parameter int unsigned SIZE  = 48,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [SIZE-1:0] wdata,
  output logic [SIZE-1:0] rdata
);

  logic [SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder with fixed access latency.
// Optional cycle-counter register at MMIO_ADDR when DMEM_MMIO_EN is defined.
module data_mem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned     SIZE      = DMEM_SIZE,
  parameter int unsigned     DEPTH     = DMEM_DEPTH,
  parameter int unsigned     LATENCY   = DMEM_LATENCY,
  parameter logic [SIZE-1:0] MMIO_ADDR = '1
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            ReqValid,
  input  logic            ReqWrite,
  input  logic [SIZE-1:0] ReqAddr,
  input  logic [SIZE-1:0] ReqWData,
  output logic            ReqReady,
  output logic            RespValid,
  output logic [SIZE-1:0] RespRData,
  output logic            RespErr,
  output logic            Busy
);

  localparam int unsigned     AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SIZE-1:0] DEPTH_W = SIZE'(DEPTH);

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] wdata_q, wdata_d;
  logic [SIZE-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_we;
  logic [SIZE-1:0] mem_rdata;
  logic            in_range;
  logic            mmio_sel;
  logic [SIZE-1:0] cyc_val;

  assign in_range = (addr_q < DEPTH_W);

`ifdef DMEM_MMIO_EN
  logic [SIZE-1:0] cyc_q, cyc_d;

  assign cyc_d    = cyc_q + 1'b1;
  assign cyc_val  = cyc_q;
  assign mmio_sel = (addr_q == MMIO_ADDR);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end
`else
  assign cyc_val  = '0;
  assign mmio_sel = 1'b0 && (addr_q == MMIO_ADDR);
`endif

  dmem_storage #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          cnt_d   = 4'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Execute edge: the store commits and the response data is captured together.
          mem_we  = write_q & in_range & ~mmio_sel;
          rdata_d = '0;
          if (!write_q) begin
            if (mmio_sel)      rdata_d = cyc_val;
            else if (in_range) rdata_d = mem_rdata;
          end
          err_d   = ~in_range & ~mmio_sel;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ReqReady  = (state_q == IDLE);
  assign Busy      = (state_q != IDLE);
  assign RespValid = (state_q == RESP);
  assign RespRData = rdata_q;
  assign RespErr   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances against a word-array model.
module tb_data_mem_responder;

  localparam logic [47:0] MMIO_A = 48'hFFFF_FFFF_FFFF;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [47:0] req_addr  = '0;
  logic [47:0] req_wdata = '0;
  int          sel = 0;

  logic        a_ready, a_valid, a_err, a_busy;
  logic [47:0] a_rdata;
  logic        b_ready, b_valid, b_err, b_busy;
  logic [47:0] b_rdata;

  logic        cur_ready, cur_valid, cur_err, cur_busy;
  logic [47:0] cur_rdata;

  int unsigned cyc_tb = 0;
  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;

  logic [47:0] mem_m [2][64];
  bit          mem_w [2][64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_tb <= cyc_tb + 1;

  data_mem_responder #(.SIZE(48), .DEPTH(64), .LATENCY(2)) u_dut_a (
    .CLK(clk), .Reset(rst), .ReqValid(req_valid && sel == 0), .ReqWrite(req_write),
    .ReqAddr(req_addr), .ReqWData(req_wdata), .ReqReady(a_ready), .RespValid(a_valid),
    .RespRData(a_rdata), .RespErr(a_err), .Busy(a_busy)
  );

  data_mem_responder #(.SIZE(48), .DEPTH(64), .LATENCY(1)) u_dut_b (
    .CLK(clk), .Reset(rst), .ReqValid(req_valid && sel == 1), .ReqWrite(req_write),
    .ReqAddr(req_addr), .ReqWData(req_wdata), .ReqReady(b_ready), .RespValid(b_valid),
    .RespRData(b_rdata), .RespErr(b_err), .Busy(b_busy)
  );

  assign cur_ready = (sel == 1) ? b_ready : a_ready;
  assign cur_valid = (sel == 1) ? b_valid : a_valid;
  assign cur_err   = (sel == 1) ? b_err   : a_err;
  assign cur_busy  = (sel == 1) ? b_busy  : a_busy;
  assign cur_rdata = (sel == 1) ? b_rdata : a_rdata;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full transaction; at_cyc != 0 forces the acceptance edge number.
  task automatic transact(input int s, input logic wr, input logic [47:0] a, input logic [47:0] d,
                          input int unsigned at_cyc, output logic [47:0] rd, output int unsigned acc);
    int unsigned lat;
    int unsigned guard;
    bit in_rng, mmio;
    lat   = (s == 1) ? 1 : 2;
    guard = 0;
    rd    = '0;
    acc   = 0;
    sel   = s;
    @(negedge clk);
    while (!cur_ready || (at_cyc != 0 && cyc_tb + 1 < at_cyc)) begin
      guard++;
      if (guard > 50) begin
        check("ready_timeout", 48'd0, 48'd1);
        return;
      end
      @(negedge clk);
    end
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    acc = cyc_tb + 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    in_rng = (a < 48'd64);
    mmio   = MMIO_EN && (a == MMIO_A);
    for (int unsigned k = 0; k <= lat + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check("busy", 48'(cur_busy), 48'(k <= lat));
      check("resp_valid", 48'(cur_valid), 48'(k == lat));
      check("req_ready", 48'(cur_ready), 48'(k == lat + 1));
      if (k == lat) begin
        rd = cur_rdata;
        check("resp_err", 48'(cur_err), 48'(!in_rng && !mmio));
        if (wr) check("store_rdata", cur_rdata, 48'd0);
        else if (!in_rng && !mmio) check("oor_rdata", cur_rdata, 48'd0);
        else if (in_rng && mem_w[s][a[5:0]]) check("load_rdata", cur_rdata, mem_m[s][a[5:0]]);
      end
      if (k == lat + 1) check("rdata_hold", cur_rdata, rd);
    end
    if (wr && in_rng) begin
      mem_m[s][a[5:0]] = d;
      mem_w[s][a[5:0]] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [47:0] rd, rd1, rd2;
    int unsigned acc, acc1, acc2;
    int unsigned accs [3];
    int unsigned n_acc;
    bit r;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 48'(a_ready), 48'd1);
    check("rst_valid", 48'(a_valid), 48'd0);
    check("rst_rdata", a_rdata, 48'd0);
    check("rst_err", 48'(a_err), 48'd0);
    check("rst_busy", 48'(a_busy), 48'd0);
    check("rst_busy_b", 48'(b_busy), 48'd0);
    @(negedge clk) rst = 1'b0;

    transact(0, 1'b1, 48'd5, 48'h0000_1234_5678, 0, rd, acc);
    transact(0, 1'b0, 48'd5, 48'd0, 0, rd, acc);
    check("dir_load5", rd, 48'h0000_1234_5678);

    // back-to-back loads with ReqValid held high
    sel = 0;
    n_acc = 0;
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 48'd5;
    req_valid = 1'b1;
    for (int unsigned i = 0; i < 20 && n_acc < 3; i++) begin
      r = a_ready;
      @(posedge clk);
      if (r) begin
        accs[n_acc] = i;
        n_acc++;
      end
      if (n_acc < 3) @(negedge clk);
    end
    #1 req_valid = 1'b0;
    check("b2b_count", 48'(n_acc), 48'd3);
    check("b2b_gap1", 48'(accs[1] - accs[0]), 48'd4);
    check("b2b_gap2", 48'(accs[2] - accs[1]), 48'd4);
    repeat (4) @(posedge clk);

    // out of range
    transact(0, 1'b1, 48'd0, 48'hA5A5_0000_5A5A, 0, rd, acc);
    transact(0, 1'b1, 48'd64, 48'h1111_2222_3333, 0, rd, acc);
    transact(0, 1'b0, 48'd0, 48'd0, 0, rd, acc);
    check("oor_addr0_kept", rd, 48'hA5A5_0000_5A5A);
    transact(0, 1'b0, 48'd64, 48'd0, 0, rd, acc);

    // reset during ACCESS of a pending store to address 3
    transact(0, 1'b1, 48'd3, 48'h0000_0BAD_F00D, 0, rd, acc);
    sel = 0;
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 48'd3;
    req_wdata = 48'hDEAD_DEAD_DEAD;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 48'(a_busy), 48'd0);
    check("rst_mid_valid", 48'(a_valid), 48'd0);
    @(negedge clk) rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check("rst_mid_no_resp", 48'(a_valid), 48'd0);
    end
    transact(0, 1'b0, 48'd3, 48'd0, 0, rd, acc);
    check("rst_mid_addr3", rd, 48'h0000_0BAD_F00D);

    // LATENCY=1 instance
    transact(1, 1'b1, 48'd7, 48'h0000_CAFE_BEEF, 0, rd, acc);
    transact(1, 1'b0, 48'd7, 48'd0, 0, rd, acc);
    check("lat1_load7", rd, 48'h0000_CAFE_BEEF);

    // cycle-counter register (ordinary out-of-range address when disabled)
    transact(0, 1'b0, MMIO_A, 48'd0, 0, rd1, acc1);
    transact(0, 1'b0, MMIO_A, 48'd0, acc1 + 10, rd2, acc2);
    check("mmio_acc_gap", 48'(acc2 - acc1), 48'd10);
    if (MMIO_EN) check("mmio_delta", rd2 - rd1, 48'd10);
    transact(0, 1'b1, MMIO_A, 48'h1234, 0, rd, acc);

    // randomized traffic on both instances
    for (int unsigned i = 0; i < 60; i++) begin
      int s;
      logic wr;
      logic [47:0] a, d;
      s  = (i % 3 == 2) ? 1 : 0;
      wr = 1'($urandom_range(0, 1));
      a  = 48'($urandom_range(0, 70));
      d  = {16'($urandom), 32'($urandom)};
      transact(s, wr, a, d, 0, rd, acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
